// File: rtl/jpc_reg_file.sv
// jpc_reg_file: 32-entry register file, x0 hardwired to zero, one read/write port and one read-only port
`ifndef JPC_REGDATA_WIDTH
`define JPC_REGDATA_WIDTH 32
`endif
module jpc_reg_file #(
  parameter int DATA_WIDTH = `JPC_REGDATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r1_idx_op_I,
  input  logic [4:0]            r1_idx_I,
  input  logic                  r1_idx_valid_I,
  output logic                  r1_idx_ready_O,
  input  logic                  r1_rdata_ready_I,
  output logic [DATA_WIDTH-1:0] r1_rdata_O,
  output logic                  r1_rdata_valid_O,
  output logic                  r1_wdata_ready_O,
  input  logic [DATA_WIDTH-1:0] r1_wdata_I,
  input  logic                  r1_wdata_valid_I,
  input  logic                  r2_idx_op_I,
  input  logic [4:0]            r2_idx_I,
  input  logic                  r2_idx_valid_I,
  output logic                  r2_idx_ready_O,
  input  logic                  r2_data_ready_I,
  output logic [DATA_WIDTH-1:0] r2_data_O,
  output logic                  r2_data_valid_O
);
  logic [DATA_WIDTH-1:0] regs [32];
  logic wr_en, rd1_en, rd2_en;
  assign r1_idx_ready_O   = !(r1_rdata_valid_O && !r1_rdata_ready_I);
  assign r1_wdata_ready_O = r1_idx_ready_O;
  assign r2_idx_ready_O   = !(r2_data_valid_O && !r2_data_ready_I);
  assign wr_en  = r1_idx_valid_I && r1_idx_op_I && r1_wdata_valid_I && r1_idx_ready_O;
  assign rd1_en = r1_idx_valid_I && !r1_idx_op_I && r1_idx_ready_O;
  assign rd2_en = r2_idx_valid_I && !r2_idx_op_I && r2_idx_ready_O;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      r1_rdata_O       <= '0;
      r1_rdata_valid_O <= 1'b0;
      r2_data_O        <= '0;
      r2_data_valid_O  <= 1'b0;
    end else begin
      if (wr_en && r1_idx_I != 5'd0) regs[r1_idx_I] <= r1_wdata_I;
      if (rd1_en) begin
        r1_rdata_O       <= (r1_idx_I == 5'd0) ? '0 : regs[r1_idx_I];
        r1_rdata_valid_O <= 1'b1;
      end else if (r1_rdata_ready_I) begin
        r1_rdata_valid_O <= 1'b0;
      end
      if (rd2_en) begin
        r2_data_O       <= (r2_idx_I == 5'd0) ? '0 : regs[r2_idx_I];
        r2_data_valid_O <= 1'b1;
      end else if (r2_data_ready_I) begin
        r2_data_valid_O <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jpc_reg_file.sv
// tb_jpc_reg_file: randomized scoreboard bench for jpc_reg_file against an array reference model
module tb_jpc_reg_file;
  logic        clk = 0;
  logic        rst = 0;
  logic        r1_idx_op_I = 0, r1_idx_valid_I = 0, r1_rdata_ready_I = 1, r1_wdata_valid_I = 0;
  logic [4:0]  r1_idx_I = 0;
  logic [31:0] r1_wdata_I = 0;
  logic        r1_idx_ready_O, r1_rdata_valid_O, r1_wdata_ready_O;
  logic [31:0] r1_rdata_O;
  logic        r2_idx_op_I = 0, r2_idx_valid_I = 0, r2_data_ready_I = 1;
  logic [4:0]  r2_idx_I = 0;
  logic        r2_idx_ready_O, r2_data_valid_O;
  logic [31:0] r2_data_O;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] model [32];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  jpc_reg_file #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .r1_idx_op_I(r1_idx_op_I), .r1_idx_I(r1_idx_I), .r1_idx_valid_I(r1_idx_valid_I),
    .r1_idx_ready_O(r1_idx_ready_O), .r1_rdata_ready_I(r1_rdata_ready_I),
    .r1_rdata_O(r1_rdata_O), .r1_rdata_valid_O(r1_rdata_valid_O),
    .r1_wdata_ready_O(r1_wdata_ready_O), .r1_wdata_I(r1_wdata_I), .r1_wdata_valid_I(r1_wdata_valid_I),
    .r2_idx_op_I(r2_idx_op_I), .r2_idx_I(r2_idx_I), .r2_idx_valid_I(r2_idx_valid_I),
    .r2_idx_ready_O(r2_idx_ready_O), .r2_data_ready_I(r2_data_ready_I),
    .r2_data_O(r2_data_O), .r2_data_valid_O(r2_data_valid_O)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // responses are accepted on the edge after a negedge that sees valid && ready
  always @(negedge clk) begin
    if (rst) begin
      if (r1_rdata_valid_O && r1_rdata_ready_I) begin
        if (q1.size() == 0) check("r1_unexpected_response", 32'd1, 32'd0);
        else check("r1_rdata", r1_rdata_O, q1.pop_front());
      end
      if (r2_data_valid_O && r2_data_ready_I) begin
        if (q2.size() == 0) check("r2_unexpected_response", 32'd1, 32'd0);
        else check("r2_data", r2_data_O, q2.pop_front());
      end
    end
  end

  // one cycle of stimulus; called at posedge+1, returns at the next posedge+1
  task automatic step(input bit v1, input bit op1, input logic [4:0] i1, input logic [31:0] wd,
                      input bit wv, input bit rr1, input bit v2, input bit op2,
                      input logic [4:0] i2, input bit rr2);
    bit a1, a2;
    r1_idx_valid_I = v1; r1_idx_op_I = op1; r1_idx_I = i1; r1_wdata_I = wd;
    r1_wdata_valid_I = wv; r1_rdata_ready_I = rr1;
    r2_idx_valid_I = v2; r2_idx_op_I = op2; r2_idx_I = i2; r2_data_ready_I = rr2;
    #1;
    a1 = !(r1_rdata_valid_O && !rr1);
    a2 = !(r2_data_valid_O && !rr2);
    check("r1_idx_ready", {31'd0, r1_idx_ready_O}, {31'd0, a1});
    check("r1_wdata_ready", {31'd0, r1_wdata_ready_O}, {31'd0, a1});
    check("r2_idx_ready", {31'd0, r2_idx_ready_O}, {31'd0, a2});
    if (v1 && a1 && !op1) q1.push_back(model[i1]);
    if (v2 && a2 && !op2) q2.push_back(model[i2]);
    if (v1 && a1 && op1 && wv && i1 != 5'd0) model[i1] = wd;
    @(posedge clk); #1;
    r1_idx_valid_I = 0; r1_wdata_valid_I = 0; r2_idx_valid_I = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
  endtask

  task automatic wr1(input logic [4:0] i, input logic [31:0] d);
    step(1, 1, i, d, 1, 1, 0, 0, 0, 1);
  endtask

  task automatic rd1(input logic [4:0] i);
    step(1, 0, i, 0, 0, 1, 0, 0, 0, 1);
  endtask

  task automatic rd2(input logic [4:0] i, input bit op);
    step(0, 0, 0, 0, 0, 1, 1, op, i, 1);
  endtask

  initial begin
    logic [4:0]  ra, rb;
    logic [31:0] va, vb;
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    check("reset_r1_valid", {31'd0, r1_rdata_valid_O}, 32'd0);
    check("reset_r2_valid", {31'd0, r2_data_valid_O}, 32'd0);
    check("reset_r1_data", r1_rdata_O, 32'd0);
    check("reset_r2_data", r2_data_O, 32'd0);
    check("reset_r1_ready", {31'd0, r1_idx_ready_O}, 32'd1);
    check("reset_r2_ready", {31'd0, r2_idx_ready_O}, 32'd1);
    check("reset_wdata_ready", {31'd0, r1_wdata_ready_O}, 32'd1);

    ra = 5'($urandom_range(1, 31));
    va = $urandom;
    wr1(ra, va); idle(1); rd1(ra); idle(2);
    wr1(0, $urandom | 32'h1); rd1(0); idle(2);
    do rb = 5'($urandom_range(1, 31)); while (rb == ra);
    vb = $urandom ^ va;
    wr1(rb, vb); rd1(rb); rd1(ra); idle(2);
    rd2(ra, 0); rd2(ra, 1); rd2(ra, 0); rd1(ra); idle(2);
    // simultaneous write and read of the same register returns the old value
    step(1, 1, ra, ~va, 1, 1, 1, 0, ra, 1); rd1(ra); idle(2);

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1), $urandom_range(0, 4) == 0, 5'($urandom),
           $urandom_range(0, 3) != 0);
    end
    idle(4);
    check("q1_drained", q1.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);

    step(1, 0, ra, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("bp_valid_held", {31'd0, r1_rdata_valid_O}, 32'd1);
      check("bp_idx_ready_low", {31'd0, r1_idx_ready_O}, 32'd0);
      check("bp_data_held", r1_rdata_O, q1[0]);
    end
    rst = 0;
    #1;
    check("rst_mid_valid", {31'd0, r1_rdata_valid_O}, 32'd0);
    check("rst_mid_data", r1_rdata_O, 32'd0);
    q1.delete(); q2.delete();
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    rd1(ra); rd2(rb, 0); idle(3);
    check("q1_final", q1.size(), 32'd0);
    check("q2_final", q2.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
